load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 176 +++++++++++++++++
 tb/tb_load_store_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RISC-V style load/store unit: byte/half/word accesses on a word-wide memory,
// splitting misaligned accesses that straddle two words into two accesses.
module load_store_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32   // only 32 is supported
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [3:0]            mem_wmask,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [2:0] {IDLE, ACC0, CAP0, ACC1, CAP1, RESP} state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     lo_q, lo_d;
  logic [DATA_W-1:0]     hi_q, hi_d;

  logic                  req_ok;
  logic [1:0]            off;
  logic [2:0]            size;
  logic [3:0]            size_mask;
  logic                  split;
  logic [7:0]            mask8;
  logic [2*DATA_W-1:0]   wdata64;
  logic [DM_ADDRESS-1:0] word0, word1;
  logic [DATA_W-1:0]     ld_word, ld_result;

  always_comb begin
    req_ok = 1'b0;
    if (req_we) req_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else        req_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                         (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
  end

  // Access geometry of the registered request.
  always_comb begin
    off = addr_q[1:0];
    case (funct3_q[1:0])
      2'b00:   begin size = 3'd1; size_mask = 4'b0001; end
      2'b01:   begin size = 3'd2; size_mask = 4'b0011; end
      default: begin size = 3'd4; size_mask = 4'b1111; end
    endcase
    split   = ({1'b0, off} + size) > 3'd4;
    mask8   = {4'b0000, size_mask} << off;
    wdata64 = {{DATA_W{1'b0}}, wdata_q} << {off, 3'b000};
    word0   = {addr_q[DM_ADDRESS-1:2], 2'b00};
    word1   = word0 + DM_ADDRESS'(4);   // top word wraps to 0
  end

  // hi_q is zero for non-split loads, so one shift covers both cases.
  always_comb begin
    ld_word = DATA_W'({hi_q, lo_q} >> {off, 3'b000});
    case (funct3_q)
      3'b000:  ld_result = {{(DATA_W-8){ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_result = {{(DATA_W-16){ld_word[15]}}, ld_word[15:0]};
      3'b100:  ld_result = {{(DATA_W-8){1'b0}}, ld_word[7:0]};
      3'b101:  ld_result = {{(DATA_W-16){1'b0}}, ld_word[15:0]};
      default: ld_result = ld_word;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_addr   = '0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_wmask  = 4'b0000;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = !req_ok;
          hi_d     = '0;
          state_d  = req_ok ? ACC0 : RESP;
        end
      end
      ACC0: begin
        mem_addr = word0;
        if (we_q) begin
          mem_wr    = 1'b1;
          mem_wmask = mask8[3:0];
          mem_wdata = wdata64[DATA_W-1:0];
          state_d   = split ? ACC1 : RESP;
        end else begin
          mem_rd  = 1'b1;
          state_d = CAP0;
        end
      end
      CAP0: begin
        lo_d    = mem_rdata;
        state_d = split ? ACC1 : RESP;
      end
      ACC1: begin
        mem_addr = word1;
        if (we_q) begin
          mem_wr    = 1'b1;
          mem_wmask = mask8[7:4];
          mem_wdata = wdata64[2*DATA_W-1:DATA_W];
          state_d   = RESP;
        end else begin
          mem_rd  = 1'b1;
          state_d = CAP1;
        end
      end
      CAP1: begin
        hi_d    = mem_rdata;
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (we_q || err_q) ? '0 : ld_result;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit against a byte-addressed
// memory model; latency N means resp_valid is high in the Nth cycle after accept.
module tb_load_store_unit;
  localparam int AW   = 9;
  localparam int MEMB = 512;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid, resp_err;
  logic [31:0]   resp_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wr;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  always #5 clk = ~clk;

  load_store_unit #(.DM_ADDRESS(AW), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct { bit wr; int addr; logic [3:0] mask; logic [31:0] data; } acc_t;
  typedef struct { logic [31:0] rdata; bit err; int lat; int accept; int n; } exp_t;

  logic [7:0] dmem [MEMB];   // memory behind the DUT's bus
  logic [7:0] rmem [MEMB];   // reference byte memory
  exp_t exp_q[$];
  acc_t exp_acc[$];
  acc_t obs[$];
  acc_t last_obs[$];
  logic [31:0] last_rdata;
  bit   last_err;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus responder: read data one cycle after mem_rd, byte-masked writes.
  always @(posedge clk) begin
    int a;
    a = int'(mem_addr);
    if (mem_rd) mem_rdata <= {dmem[a+3], dmem[a+2], dmem[a+1], dmem[a]};
    if (mem_wr)
      for (int l = 0; l < 4; l++)
        if (mem_wmask[l]) dmem[a+l] <= mem_wdata[8*l +: 8];
  end

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int l = 0; l < 4; l++) if (m[l]) r[8*l +: 8] = 8'hFF;
    return r;
  endfunction

  // Reference: byte-level semantics, memory addresses wrap modulo MEMB.
  task automatic model_push(input bit we, input logic [2:0] f3, input int addr,
                            input logic [31:0] wd, input int acc_cyc);
    exp_t e; acc_t x; int size; bit ok; bit split; int words[$]; int b; int w;
    logic [31:0] v; bit seen;
    ok = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    split = ((addr % 4) + size) > 4;
    e.err = !ok; e.rdata = '0; e.n = 0; e.accept = acc_cyc;
    if (!ok) e.lat = 1;
    else begin
      e.lat = we ? (split ? 3 : 2) : (split ? 5 : 3);
      for (int i = 0; i < size; i++) begin
        w = ((addr + i) % MEMB) & ~3;
        seen = 0;
        foreach (words[k]) if (words[k] == w) seen = 1;
        if (!seen) words.push_back(w);
      end
      e.n = words.size();
      if (!we) begin
        v = '0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = rmem[(addr + i) % MEMB];
        if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
        e.rdata = v;
        foreach (words[k]) begin
          x.wr = 0; x.addr = words[k]; x.mask = '0; x.data = '0;
          exp_acc.push_back(x);
        end
      end else begin
        foreach (words[k]) begin
          x.wr = 1; x.addr = words[k]; x.mask = '0; x.data = '0;
          for (int i = 0; i < size; i++) begin
            b = (addr + i) % MEMB;
            if ((b & ~3) == words[k]) begin
              x.mask[b % 4] = 1'b1;
              x.data[8*(b % 4) +: 8] = wd[8*i +: 8];
            end
          end
          exp_acc.push_back(x);
        end
        for (int i = 0; i < size; i++) rmem[(addr + i) % MEMB] = wd[8*i +: 8];
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: bus protocol every cycle, scoreboard on each response.
  always @(negedge clk) begin
    acc_t o, x; exp_t e;
    if (!reset) begin
      chk(!(mem_rd && mem_wr), "rd_wr_exclusive", {mem_rd, mem_wr}, 0);
      chk(!mem_wr || mem_wmask != 0, "wr_mask_nonzero", 32'(mem_wmask), 1);
      chk(mem_addr[1:0] == 2'b00, "addr_aligned", 32'(mem_addr), 0);
      chk(!(resp_valid && req_ready), "ready_only_idle", 32'(req_ready), 0);
      if (!mem_rd && !mem_wr)
        chk(mem_addr == 0 && mem_wdata == 0 && mem_wmask == 0, "bus_quiet", mem_wdata, 0);
    end
    if (mem_rd || mem_wr) begin
      o.wr = mem_wr; o.addr = int'(mem_addr); o.mask = mem_wmask; o.data = mem_wdata;
      obs.push_back(o);
    end
    if (resp_valid) begin
      if (exp_q.size() == 0) chk(0, "unexpected_resp", resp_rdata, 0);
      else begin
        e = exp_q.pop_front();
        chk(resp_err == e.err, "resp_err", 32'(resp_err), 32'(e.err));
        chk(resp_rdata == e.rdata, "resp_rdata", resp_rdata, e.rdata);
        chk(cyc - e.accept + 1 == e.lat, "latency", cyc - e.accept + 1, e.lat);
        last_obs.delete();
        for (int k = 0; k < e.n; k++) begin
          x = exp_acc.pop_front();
          if (obs.size() == 0) chk(0, "missing_access", k, e.n);
          else begin
            o = obs.pop_front();
            last_obs.push_back(o);
            chk(o.wr == x.wr, "access_kind", 32'(o.wr), 32'(x.wr));
            chk(o.addr == x.addr, "access_addr", o.addr, x.addr);
            if (x.wr) begin
              chk(o.mask == x.mask, "access_mask", 32'(o.mask), 32'(x.mask));
              chk((o.data & lanes(x.mask)) == x.data, "access_data", o.data & lanes(x.mask), x.data);
            end
          end
        end
        chk(obs.size() == 0, "extra_access", obs.size(), 0);
        obs.delete();
        last_rdata = resp_rdata;
        last_err = resp_err;
      end
    end
  end

  task automatic junk();
    req_valid = 1'($urandom); req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = AW'($urandom); req_wdata = $urandom;
  endtask

  task automatic issue(input bit we, input logic [2:0] f3, input logic [AW-1:0] addr, input logic [31:0] wd);
    int t;
    @(negedge clk);
    t = 0;
    while (!req_ready && t < 50) begin junk(); @(negedge clk); t++; end
    if (!req_ready) begin chk(0, "ready_timeout", 0, 1); req_valid = 0; return; end
    model_push(we, f3, int'(addr), wd, cyc + 1);
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    t = 0;
    while (!req_ready && t < 50) begin junk(); @(negedge clk); t++; end
    req_valid = 0;
    chk(req_ready, "done_timeout", 32'(req_ready), 1);
    chk(exp_q.size() == 0, "resp_seen", exp_q.size(), 0);
  endtask

  task automatic setw(input int a, input logic [31:0] w);
    for (int l = 0; l < 4; l++) begin dmem[a+l] = w[8*l +: 8]; rmem[a+l] = w[8*l +: 8]; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bv;
    logic [2:0] f3;
    bit we;
    int nbad;
    logic [2:0] ld_ok[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < MEMB; i++) begin bv = 8'($urandom); dmem[i] = bv; rmem[i] = bv; end
    repeat (3) @(negedge clk);
    reset = 0;
    chk(req_ready == 1, "rst_req_ready", 32'(req_ready), 1);
    chk(resp_valid == 0, "rst_resp_valid", 32'(resp_valid), 0);
    chk(resp_err == 0, "rst_resp_err", 32'(resp_err), 0);
    chk(resp_rdata == 0, "rst_resp_rdata", resp_rdata, 0);
    chk(mem_rd == 0 && mem_wr == 0, "rst_strobes", {mem_rd, mem_wr}, 0);
    chk(mem_wmask == 0 && mem_addr == 0 && mem_wdata == 0, "rst_bus", mem_wdata, 0);

    setw(32'h010, 32'hDEADBEEF);
    issue(0, 3'b010, 9'h010, 0);
    chk(last_rdata == 32'hDEADBEEF, "lw_aligned", last_rdata, 32'hDEADBEEF);
    chk(last_obs.size() == 1, "lw_one_read", last_obs.size(), 1);

    setw(32'h010, 32'h80FF1234);
    issue(0, 3'b000, 9'h013, 0);
    chk(last_rdata == 32'hFFFFFF80, "lb_sext", last_rdata, 32'hFFFFFF80);
    issue(0, 3'b100, 9'h013, 0);
    chk(last_rdata == 32'h00000080, "lbu_zext", last_rdata, 32'h00000080);

    setw(32'h1FC, 32'hAABBCCDD);
    setw(32'h000, 32'h11223344);
    issue(0, 3'b010, 9'h1FE, 0);
    chk(last_rdata == 32'h3344AABB, "lw_split_wrap", last_rdata, 32'h3344AABB);
    chk(last_obs.size() == 2 && last_obs[0].addr == 32'h1FC && last_obs[1].addr == 0,
        "lw_split_addrs", last_obs.size(), 2);

    issue(1, 3'b001, 9'h007, 32'h0000BEEF);
    chk(last_obs.size() == 2 && last_obs[0].addr == 4 && last_obs[0].mask == 4'b1000 &&
        last_obs[0].data == 32'hEF000000, "sh_split_lo", last_obs.size(), 2);
    chk(last_obs.size() == 2 && last_obs[1].addr == 8 && last_obs[1].mask == 4'b0001 &&
        last_obs[1].data == 32'h000000BE, "sh_split_hi", last_obs.size(), 2);

    issue(0, 3'b011, 9'h020, 0);
    chk(last_err == 1 && last_rdata == 0, "bad_funct3", last_rdata, 0);
    chk(last_obs.size() == 0, "bad_funct3_noacc", last_obs.size(), 0);

    for (int n = 0; n < 300; n++) begin
      repeat ($urandom % 3) @(negedge clk);
      we = 1'($urandom);
      if ($urandom % 5 == 0) f3 = 3'($urandom);
      else f3 = we ? 3'($urandom % 3) : ld_ok[$urandom % 5];
      issue(we, f3, AW'($urandom), $urandom);
    end

    // Reset during CAP0 of a split load aborts it.
    @(negedge clk);
    obs.delete();
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 9'h1FE;
    @(negedge clk); req_valid = 0;
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    chk(req_ready == 1, "rst_cap0_idle", 32'(req_ready), 1);
    repeat (8) @(negedge clk);
    chk(obs.size() == 1, "rst_cap0_one_read", obs.size(), 1);
    obs.delete();

    // Reset wins over a simultaneous request.
    reset = 1; req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 9'h010;
    @(negedge clk); reset = 0; req_valid = 0;
    repeat (6) @(negedge clk);
    chk(obs.size() == 0, "rst_prio_noacc", obs.size(), 0);
    chk(req_ready == 1, "rst_prio_ready", 32'(req_ready), 1);

    nbad = 0;
    for (int i = 0; i < MEMB; i++) if (dmem[i] !== rmem[i]) nbad++;
    chk(nbad == 0, "mem_final", nbad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
